// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/serial_sub_n_fs_cell.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_n.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock, through a single fs_cell.
module serial_sub_n
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] diff_next;

  fs_cell u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // The bit being produced this cycle lands in the MSB; earlier bits shift down.
  assign diff_next = {d_bit, sd[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            sd    <= '0;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= diff_next;
          br  <= bo_bit;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // On the MSB cycle sa[0]/sb[0] are the operand sign bits and d_bit is the result sign.
            diff  <= diff_next;
            bout  <= bo_bit;
            ovf   <= (sa[0] ^ sb[0]) & (d_bit ^ sa[0]);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed bench for serial_sub_n: WIDTH=8 instance for latency/chaining/streaming/reset, WIDTH=4 instance exhaustive.
module tb_serial_sub_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  serial_sub_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_sub_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {diff, bout, ovf} for a w-bit a - b - bi.
  function automatic logic [33:0] ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic bi);
    longint m, r, sa, sb, s;
    logic [63:0] rr;
    logic bo, ov;
    m  = longint'(1) << w;
    r  = longint'(a) - longint'(b) - longint'(bi);
    bo = (r < 0);
    if (r < 0) r = r + m;
    rr = 64'(r);
    sa = (a >= 32'(m / 2)) ? longint'(a) - m : longint'(a);
    sb = (b >= 32'(m / 2)) ? longint'(b) - m : longint'(b);
    s  = sa - sb - longint'(bi);
    ov = (s < -(m / 2)) || (s >= (m / 2));
    return {rr[31:0], bo, ov};
  endfunction

  // Issues one operation on dut8 (caller sits #1 after a rising edge); returns at the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; bin8 = ~bi;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int lat;
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    logic [33:0] q[$];
    logic [33:0] last4;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outs8", {busy8, done8, diff8, bout8, ovf8}, '0);
    chk("reset_outs4", {busy4, done4, diff4, bout4, ovf4}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic subtraction, latency and busy
    op8(8'h05, 8'h03, 1'b0, lat);
    chk("lat_basic", lat, 8);
    chk("res_05_03", {diff8, bout8, ovf8}, {8'h02, 1'b0, 1'b0});
    chk("busy_in_done", busy8, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", done8, 1'b0);

    op8(8'h00, 8'h01, 1'b0, lat);
    chk("res_00_01", {diff8, bout8, ovf8}, {8'hFF, 1'b1, 1'b0});
    @(posedge clk); #1;
    op8(8'h80, 8'h01, 1'b0, lat);
    chk("res_80_01", {diff8, bout8, ovf8}, {8'h7F, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("hold_after_done", {diff8, bout8, ovf8}, {8'h7F, 1'b0, 1'b1});

    // Chaining two words through bout -> bin
    op8(8'h00, 8'h00, 1'b1, lat);
    chk("chain_lo", {diff8, bout8, ovf8}, {8'hFF, 1'b1, 1'b0});
    @(posedge clk); #1;
    op8(8'h01, 8'h00, bout8, lat);
    chk("chain_hi", {diff8, bout8, ovf8}, {8'h00, 1'b0, 1'b0});
    @(posedge clk); #1;

    // start held for 20 cycles, operands changing every cycle
    nd = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 20) begin
        a8 = 8'(i * 7 + 3); b8 = 8'(i * 3); bin8 = i[0]; start8 = 1'b1;
        if (i % 9 == 0) q.push_back(ref_sub(8, 32'(a8), 32'(b8), bin8));
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 4) chk("no_update_mid_run", {diff8, bout8, ovf8}, {8'h00, 1'b0, 1'b0});
      if (done8) begin
        chk("stream_when", i, 8 + 9 * nd);
        if (nd < 3) chk("stream_res", {diff8, bout8, ovf8}, q[nd]);
        nd++;
      end
    end
    chk("stream_count", nd, 3);

    // Reset in the middle of RUN
    op8(8'h40, 8'h10, 1'b0, lat);
    chk("pre_abort", {diff8, bout8, ovf8}, {8'h30, 1'b0, 1'b0});
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy8, done8, diff8, bout8, ovf8}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    chk("abort_no_done", nd, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    op8(8'h33, 8'h11, 1'b0, lat);
    chk("after_reset_lat", lat, 8);
    chk("after_reset_res", {diff8, bout8, ovf8}, {8'h22, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Exhaustive WIDTH=4
    last4 = '0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          op4(4'(ai), 4'(bi), ci[0]);
          last4 = ref_sub(4, 32'(ai), 32'(bi), ci[0]);
          chk("exh4", {diff4, bout4, ovf4}, last4);
          @(posedge clk); #1;
        end
      end
    end

    // X on idle inputs must not reach the outputs
    a4 = 'x; b4 = 'x; bin4 = 1'bx; start4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("x_idle_hold", {busy4, done4, diff4, bout4, ovf4}, {2'b00, last4[5:0]});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
